// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared glyph constants and event classification types
package count_disp_pkg;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Relationship between the previous and the current counter sample
    typedef enum logic [2:0] {
        EV_NONE,
        EV_STEP,
        EV_OVF,
        EV_UNF,
        EV_JUMP
    } event_kind_t;

    // Hex glyph lookup for a zero-extended count value
    function automatic logic [6:0] glyph(input logic [3:0] value);
        return SEG_GLYPH[value];
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - retriggerable down-counter that stretches a strobe into an LED pulse
module pulse_stretcher #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic led
);

    localparam int TW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [TW-1:0] timer;

    // Load on trigger (also while already running), otherwise count down to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (trig) begin
            timer <= TW'(CYCLES);
        end else if (timer != '0) begin
            timer <= timer - TW'(1);
        end
    end

    // LED is lit from the trigger edge for exactly CYCLES cycles
    assign led = (timer != '0);

endmodule

// File: rtl/count_display_monitor.sv
// rtl/count_display_monitor.sv - registers counter value, drives 7-segment digit and wrap indicators
import count_disp_pkg::*;

module count_display_monitor #(
    parameter int CNT_W          = 3,
    parameter int STRETCH_CYCLES = 25_000_000,
    parameter int WRAP_TOT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CNT_W-1:0]      count,
    input  logic                  up_down,
    output logic [6:0]            seg,
    output logic                  dir_led,
    output logic                  ovf_pulse,
    output logic                  unf_pulse,
    output logic                  ovf_led,
    output logic                  unf_led,
    output logic                  jump_pulse,
    output logic [WRAP_TOT_W-1:0] ovf_total,
    output logic [WRAP_TOT_W-1:0] unf_total
);

    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [WRAP_TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             valid;
    event_kind_t      ev_kind;
    logic             ovf_det;
    logic             unf_det;
    logic             jump_det;

    // Classify the incoming sample against the previous one; nothing flags before the first sample
    always_comb begin
        ev_kind = EV_NONE;
        if (valid && (count != cnt_q)) begin
            if ((cnt_q == CNT_MAX) && (count == '0)) begin
                ev_kind = EV_OVF;
            end else if ((cnt_q == '0) && (count == CNT_MAX)) begin
                ev_kind = EV_UNF;
            end else if ((count == cnt_q + CNT_W'(1)) || (count == cnt_q - CNT_W'(1))) begin
                ev_kind = EV_STEP;
            end else begin
                ev_kind = EV_JUMP;
            end
        end
    end

    assign ovf_det  = (ev_kind == EV_OVF);
    assign unf_det  = (ev_kind == EV_UNF);
    assign jump_det = (ev_kind == EV_JUMP);

    // Sample registers, one-cycle strobes and saturating wrap totals
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            valid      <= 1'b0;
            seg        <= SEG_GLYPH[0];
            dir_led    <= 1'b0;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            jump_pulse <= 1'b0;
            ovf_total  <= '0;
            unf_total  <= '0;
        end else begin
            cnt_q      <= count;
            valid      <= 1'b1;
            seg        <= glyph(4'(count));
            dir_led    <= up_down;
            ovf_pulse  <= ovf_det;
            unf_pulse  <= unf_det;
            jump_pulse <= jump_det;
            if (ovf_det && (ovf_total != TOT_MAX)) begin
                ovf_total <= ovf_total + WRAP_TOT_W'(1);
            end
            if (unf_det && (unf_total != TOT_MAX)) begin
                unf_total <= unf_total + WRAP_TOT_W'(1);
            end
        end
    end

    pulse_stretcher #(
        .CYCLES (STRETCH_CYCLES)
    ) u_ovf_stretch (
        .clk   (clk),
        .reset (reset),
        .trig  (ovf_det),
        .led   (ovf_led)
    );

    pulse_stretcher #(
        .CYCLES (STRETCH_CYCLES)
    ) u_unf_stretch (
        .clk   (clk),
        .reset (reset),
        .trig  (unf_det),
        .led   (unf_led)
    );

endmodule

// File: tb/tb_count_display_monitor.sv
// tb/tb_count_display_monitor.sv - randomized and directed bench with a behavioural reference model
module tb_count_display_monitor;

    localparam int CNT_W   = 3;
    localparam int STRETCH = 4;
    localparam int TOT_W   = 8;
    localparam int MODN    = 8;
    localparam int TOTSAT  = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] count;
    logic             up_down;
    logic [6:0]       seg;
    logic             dir_led;
    logic             ovf_pulse;
    logic             unf_pulse;
    logic             ovf_led;
    logic             unf_led;
    logic             jump_pulse;
    logic [TOT_W-1:0] ovf_total;
    logic [TOT_W-1:0] unf_total;

    count_display_monitor #(
        .CNT_W          (CNT_W),
        .STRETCH_CYCLES (STRETCH),
        .WRAP_TOT_W     (TOT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .up_down    (up_down),
        .seg        (seg),
        .dir_led    (dir_led),
        .ovf_pulse  (ovf_pulse),
        .unf_pulse  (unf_pulse),
        .ovf_led    (ovf_led),
        .unf_led    (unf_led),
        .jump_pulse (jump_pulse),
        .ovf_total  (ovf_total),
        .unf_total  (unf_total)
    );

    always #5 clk = ~clk;

    logic [6:0] tb_glyph [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks_total  = 0;
    int checks_passed = 0;

    int m_prev, m_valid, m_ovf_left, m_unf_left, m_ovf_tot, m_unf_tot;
    int e_ovf_p, e_unf_p, e_jump_p, e_dir;
    logic [6:0] e_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_prev = 0; m_valid = 0; m_ovf_left = 0; m_unf_left = 0;
        m_ovf_tot = 0; m_unf_tot = 0;
        e_ovf_p = 0; e_unf_p = 0; e_jump_p = 0; e_dir = 0;
        e_seg = tb_glyph[0];
    endtask

    task automatic model_edge(input int c, input int ud);
        int d;
        int o, u, j;
        o = 0; u = 0; j = 0;
        if (m_valid != 0 && c != m_prev) begin
            d = (c - m_prev + MODN) % MODN;
            if (d == 1 && m_prev == MODN - 1)      o = 1;
            else if (d == MODN - 1 && m_prev == 0) u = 1;
            else if (d != 1 && d != MODN - 1)      j = 1;
        end
        e_ovf_p = o; e_unf_p = u; e_jump_p = j;
        m_ovf_left = o ? STRETCH : (m_ovf_left > 0 ? m_ovf_left - 1 : 0);
        m_unf_left = u ? STRETCH : (m_unf_left > 0 ? m_unf_left - 1 : 0);
        if (o && m_ovf_tot < TOTSAT) m_ovf_tot++;
        if (u && m_unf_tot < TOTSAT) m_unf_tot++;
        m_prev = c; m_valid = 1;
        e_seg = tb_glyph[c];
        e_dir = ud;
    endtask

    task automatic check_all(input string where);
        chk({where, ":seg"},        32'(seg),        32'(e_seg));
        chk({where, ":dir_led"},    32'(dir_led),    32'(e_dir));
        chk({where, ":ovf_pulse"},  32'(ovf_pulse),  32'(e_ovf_p));
        chk({where, ":unf_pulse"},  32'(unf_pulse),  32'(e_unf_p));
        chk({where, ":jump_pulse"}, 32'(jump_pulse), 32'(e_jump_p));
        chk({where, ":ovf_led"},    32'(ovf_led),    32'(m_ovf_left > 0));
        chk({where, ":unf_led"},    32'(unf_led),    32'(m_unf_left > 0));
        chk({where, ":ovf_total"},  32'(ovf_total),  32'(m_ovf_tot));
        chk({where, ":unf_total"},  32'(unf_total),  32'(m_unf_tot));
    endtask

    task automatic step(input int c, input int ud, input string where);
        count   = CNT_W'(c);
        up_down = ud[0];
        @(posedge clk);
        model_edge(c, ud);
        #1;
        check_all(where);
    endtask

    task automatic do_reset(input int cycles, input string where);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all(where);
        end
        reset = 1'b0;
    endtask

    initial begin
        int cur, r, ud;
        reset   = 1'b1;
        count   = '0;
        up_down = 1'b0;
        model_reset();

        // Reset state, then hold at 3: first sample and holds never flag
        do_reset(2, "reset");
        step(3, 1, "hold3_a");
        chk("seg_glyph3", 32'(seg), 32'h30);
        step(3, 1, "hold3_b");
        step(3, 1, "hold3_c");

        // Overflow 6,7,0 then hold to watch the LED expire
        step(6, 1, "ovf_6");
        step(7, 1, "ovf_7");
        step(0, 1, "ovf_0");
        chk("ovf_pulse_hi", 32'(ovf_pulse), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 1, "ovf_hold");
        chk("ovf_total_1", 32'(ovf_total), 32'd1);

        // Underflow 1,0,7 counting down
        step(1, 0, "unf_1");
        step(0, 0, "unf_0");
        step(7, 0, "unf_7");
        chk("unf_pulse_hi", 32'(unf_pulse), 32'd1);
        chk("dir_led_down", 32'(dir_led), 32'd0);
        for (int i = 0; i < 5; i++) step(7, 0, "unf_hold");

        // Alternating wraps: second overflow retriggers the stretcher
        step(0, 1, "alt_0a");
        step(7, 0, "alt_7");
        step(0, 1, "alt_0b");
        chk("ovf_led_retrig", 32'(ovf_led), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 1, "alt_hold");

        // Counter-reset style jump 5 -> 0
        step(5, 1, "jump_5");
        step(0, 1, "jump_0");
        chk("jump_pulse_hi", 32'(jump_pulse), 32'd1);

        // Randomized mix of steps, holds and jumps
        cur = 0;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      cur = (cur + 1) % MODN;
            else if (r < 7) cur = (cur + MODN - 1) % MODN;
            else if (r < 8) cur = cur;
            else            cur = int'($urandom_range(0, MODN - 1));
            ud = (r < 4) ? 1 : int'($urandom_range(0, 1));
            step(cur, ud, "rand");
        end

        // Free-running up count saturates the overflow total
        do_reset(1, "reset2");
        for (int i = 0; i < 300 * MODN; i++) step(i % MODN, 1, "free");
        chk("ovf_total_sat", 32'(ovf_total), 32'd255);

        // Reset while the overflow LED is lit cancels everything at that edge
        step(7, 1, "pre_rst_7");
        step(0, 1, "pre_rst_0");
        step(1, 1, "pre_rst_1");
        chk("ovf_led_active", 32'(ovf_led), 32'd1);
        count = CNT_W'(2);
        do_reset(1, "mid_rst");
        chk("mid_rst_ovf_led", 32'(ovf_led), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'h40);
        step(2, 1, "post_rst");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/count_display_monitor.md
Name: count_display_monitor

Overview:
- Downstream consumer of the 3-bit up/down counter.
- Registers the counter value and drives an active-low 7-segment digit plus a direction LED.
- Detects wrap events (MAX->0 overflow, 0->MAX underflow) and stretches each into a visible LED pulse.
- Keeps a saturating count of wrap events for board-level debug.

Parameters:
- CNT_W, 3, width of the incoming count; legal range 2..4.
- STRETCH_CYCLES, 25_000_000, LED on-time per wrap event in clk cycles; must be >=1; bench uses 4.
- WRAP_TOT_W, 8, width of the saturating wrap totals.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- count  in  CNT_W  counter value, sampled every rising clk edge.
- up_down  in  1  counter direction (1 = up), sampled for display only.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, hex glyph of the registered count.
- dir_led  out  1  registered up_down.
- ovf_pulse  out  1  one-cycle strobe on overflow detection.
- unf_pulse  out  1  one-cycle strobe on underflow detection.
- ovf_led  out  1  stretched overflow indicator.
- unf_led  out  1  stretched underflow indicator.
- jump_pulse  out  1  one-cycle strobe when count changes by other than +/-1 modulo 2^CNT_W.
- ovf_total  out  WRAP_TOT_W  saturating overflow count.
- unf_total  out  WRAP_TOT_W  saturating underflow count.

Behaviour:
- Reset: all registers clear when reset=1 at a clk edge.
  - seg=7'b1000000 (glyph "0"); cnt_q=0; valid=0.
  - All other outputs 0.
  - Timers and totals are 0.
  - Reset mid-stretch cancels the LED immediately, at the next edge.
- Sampling: every non-reset edge loads cnt_q<=count, dir_led<=up_down, seg<=glyph(count), valid<=1.
  - Latency from count to seg is 1 cycle.
- Detection: combinational comparison of count (new) against cnt_q (previous). Results are registered into the pulse outputs, so each strobe is high in the cycle after count shows the new value.
  - Comparisons are ignored while valid=0, i.e. the first sample after reset never flags.
  - Overflow: cnt_q==2^CNT_W-1 and count==0.
  - Underflow: cnt_q==0 and count==2^CNT_W-1.
  - Step: count==cnt_q+1 or count==cnt_q-1, non-wrapping. No flag.
  - Hold: count==cnt_q. No flag.
  - Jump: any other change (e.g. the counter's own reset from 5 to 0). Sets jump_pulse. Never counted as a wrap.
  - Overflow and underflow are mutually exclusive for CNT_W>=2; no priority is needed.
- Stretch, per flag, via an independent down-counter.
  - The detection edge loads the timer with STRETCH_CYCLES, and the LED is high from that edge.
  - LED = (timer != 0). The timer decrements each cycle.
  - The LED stays high for exactly STRETCH_CYCLES cycles.
  - A new event while the LED is lit reloads the timer (retrigger); there is no gap.
- Totals: increment on the same edge as the corresponding pulse and saturate at 2^WRAP_TOT_W-1. Only reset clears them.
- Steady-state counting: with count continuously incrementing, ovf_pulse fires once every 2^CNT_W cycles.

Decomposition:
- Shared package count_disp_pkg holds:
  - SEG_GLYPH[0:15], the active-low hex segment constants;
  - SEG_BLANK = 7'b1111111;
  - an event-kind enum {EV_NONE, EV_STEP, EV_OVF, EV_UNF, EV_JUMP} used by the classifier.
- One sub-module: pulse_stretcher.
  - Parameter CYCLES; ports clk, reset, trig, led.
  - Instantiated twice, for overflow and underflow.

Test Plan (STRETCH_CYCLES=4):
- Reset, then count held at 3 for 3 cycles -> seg=glyph(3)=7'b0110000 one cycle after release; no pulses (first-sample suppression and hold).
- count 6,7,0 on consecutive cycles -> ovf_pulse high exactly 1 cycle, the cycle after 0 is presented.
  - ovf_led high exactly 4 cycles; ovf_total=1; unf signals stay 0.
- count 1,0,7 -> unf_pulse once; unf_led 4 cycles; unf_total=1; dir_led follows up_down=0 with 1-cycle delay.
- count 7,0,7,0 alternating -> ovf, unf, ovf strobes.
  - Second ovf reloads the timer: ovf_led remains high continuously, through 4 cycles after the last ovf.
- count 5 then 0 (counter reset) -> jump_pulse once; no ovf/unf; totals unchanged.
- Free-running up count for 300*8 cycles -> ovf_total saturates at 255.
  - Assert reset for 1 cycle during an active ovf_led -> all outputs 0 after that edge; seg=glyph(0).
